regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port register file with an integrated busy-bit scoreboard: the next-generation register file for the processor datapath. Two combinational read ports and two write ports: port 0 is the single-cycle ALU writeback, port 1 is the long-latency writeback from memory or multiply/divide. Each register carries a busy bit that is set at issue and cleared by its port-1 writeback. Decode uses the busy outputs for hazard stalls; optional write-to-read bypass removes the writeback-stage bubble.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset_n  in  1  asynchronous, active-low reset; clears all registers and busy bits
- ctrl_writeEnable  in  1  write port 0 enable
- ctrl_writeReg  in  ADDR_WIDTH  write port 0 address
- data_writeReg  in  DATA_WIDTH  write port 0 data
- ctrl_writeEnable1  in  1  write port 1 enable; also clears the target busy bit
- ctrl_writeReg1  in  ADDR_WIDTH  write port 1 address
- data_writeReg1  in  DATA_WIDTH  write port 1 data
- ctrl_busySet  in  1  mark ctrl_busyReg pending
- ctrl_busyReg  in  ADDR_WIDTH  register to mark pending
- ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read addresses
- data_readRegA, data_readRegB  out  DATA_WIDTH  read data
- busy_readRegA, busy_readRegB  out  1  busy bit of the addressed register
- stall  out  1  busy_readRegA | busy_readRegB

## Operation
- Storage: NUM_REGS-1 flops of DATA_WIDTH (reg 1..NUM_REGS-1); register 0 has no storage.
- Register 0: always reads 0, busy always reads 0, writes and busySet to it ignored.
- Write: on clock edge, port 0 writes if ctrl_writeEnable; port 1 writes if ctrl_writeEnable1.
- Same-register dual write: port 0 wins (younger instruction); port 1 still clears the busy bit.
- Busy bits: set on edge by ctrl_busySet; cleared on edge by ctrl_writeEnable1 to that register. Set and clear of the same register in one cycle: set wins (new issue after old completion). Port 0 writes never touch busy bits.
- Read (combinational), BYPASS=1, priority: address 0 -> 0; port 0 write hit -> data_writeReg; port 1 write hit -> data_writeReg1; else stored value.
- Read, BYPASS=0: address 0 -> 0, else stored value.
- Busy read, BYPASS=1: stored bit, forced 0 when port 1 is writing that register this cycle. BYPASS=0: stored bit only.
- busySet does not affect busy outputs until the following cycle.
- No tri-state drivers; read ports are mux-based.

## Timing
- Reset: async assertion immediately forces all registers to 0 and all busy bits to 0; data_readRegA/B = 0, busy_readRegA/B = 0, stall = 0 while asserted (bypass inputs ignored during reset). Deassertion is synchronised externally; first write takes effect on the first rising edge after deassertion.
- Write latency: stored value visible 1 cycle after the write edge; with BYPASS=1 also visible combinationally in the write cycle.
- Busy latency: set/clear visible after the edge; port-1 clear visible same cycle with BYPASS=1.
- Reset mid-write: write lost; register reads 0.
- Read path is purely combinational; no read latency.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert ctrl_reset_n=0 between edges -> data_readRegA(r5) drops to 0 without a clock edge; busy all 0.
- r0: write 0xFFFFFFFF to r0 on both ports, busySet r0 -> reads 0, busy_readRegA 0, stall 0.
- Dual write collision: port0 r7=0x11, port1 r7=0x22 same cycle, busy r7 previously set -> next cycle r7 reads 0x11, busy r7 = 0.
- Bypass: BYPASS=1, read r3 while port 0 writes 0xCAFE to r3 -> same-cycle data_readRegA=0xCAFE; BYPASS=0 -> old value until next cycle.
- Scoreboard: busySet r9 -> next cycle busy_readRegB=1, stall=1; port1 write 0x1234 to r9 -> BYPASS=1 same cycle busy 0, data 0x1234, stall 0.
- Set/clear race: busySet r4 and port1 write r4 same cycle -> next cycle busy r4 = 1, r4 = port1 data.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: two write ports, busy-set issue port, two read ports.
// The master drives writes/reads (datapath); the slave is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  ctrl_writeEnable1;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg1;
    logic [DATA_WIDTH-1:0] data_writeReg1;
    logic                  ctrl_busySet;
    logic [ADDR_WIDTH-1:0] ctrl_busyReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  busy_readRegA;
    logic                  busy_readRegB;
    logic                  stall;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_writeEnable1, ctrl_writeReg1, data_writeReg1,
        output ctrl_busySet, ctrl_busyReg,
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, stall
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_writeEnable1, ctrl_writeReg1, data_writeReg1,
        input  ctrl_busySet, ctrl_busyReg,
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read / 2-write register file with per-register busy scoreboard and optional
// write-to-read forwarding. Port 0 = ALU writeback, port 1 = long-latency writeback.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                clock,
    input  logic                ctrl_reset_n,
    regfile_scoreboard_if.slave rf
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Register 0 is hardwired to zero, so storage starts at index 1.
    data_t               regs_q [1:NUM_REGS-1];
    data_t               regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;

    logic we0;
    logic we1;
    logic bset;

    assign we0  = rf.ctrl_writeEnable  && (rf.ctrl_writeReg  != '0);
    assign we1  = rf.ctrl_writeEnable1 && (rf.ctrl_writeReg1 != '0);
    assign bset = rf.ctrl_busySet      && (rf.ctrl_busyReg   != '0);

    // Port 0 is applied after port 1 so the younger ALU result wins a collision;
    // busy set is applied after the port-1 clear so a new issue survives completion.
    always_comb begin
        // NOTE: full defaults before the per-register updates keep this purely combinational (no latches).
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we1 && (rf.ctrl_writeReg1 == addr_t'(i))) begin
                regs_d[i] = rf.data_writeReg1;
                busy_d[i] = 1'b0;
            end
            if (we0 && (rf.ctrl_writeReg == addr_t'(i))) begin
                regs_d[i] = rf.data_writeReg;
            end
            if (bset && (rf.ctrl_busyReg == addr_t'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            // NOTE: the storage array is reset because software may read any register right after reset.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    addr_t raddr [2];
    data_t rdata [2];
    logic  rbusy [2];

    assign raddr[0] = rf.ctrl_readRegA;
    assign raddr[1] = rf.ctrl_readRegB;

    // Forwarding is suppressed while in reset so outputs read zero regardless of write inputs.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (raddr[p] != '0) begin
                rdata[p] = regs_q[raddr[p]];
                rbusy[p] = busy_q[raddr[p]];
                if (BYPASS && ctrl_reset_n) begin
                    if (we0 && (rf.ctrl_writeReg == raddr[p])) begin
                        rdata[p] = rf.data_writeReg;
                    end else if (we1 && (rf.ctrl_writeReg1 == raddr[p])) begin
                        rdata[p] = rf.data_writeReg1;
                    end
                    if (we1 && (rf.ctrl_writeReg1 == raddr[p])) begin
                        rbusy[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign rf.data_readRegA = rdata[0];
    assign rf.data_readRegB = rdata[1];
    assign rf.busy_readRegA = rbusy[0];
    assign rf.busy_readRegB = rbusy[1];
    assign rf.stall         = rbusy[0] | rbusy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance share identical
// stimulus; directed scenarios plus random traffic checked against an array model.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clock = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();
    regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_n ();

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut_b (
        .clock(clock), .ctrl_reset_n(rst_n), .rf(if_b));
    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_n (
        .clock(clock), .ctrl_reset_n(rst_n), .rf(if_n));

    assign if_n.ctrl_writeEnable  = if_b.ctrl_writeEnable;
    assign if_n.ctrl_writeReg     = if_b.ctrl_writeReg;
    assign if_n.data_writeReg     = if_b.data_writeReg;
    assign if_n.ctrl_writeEnable1 = if_b.ctrl_writeEnable1;
    assign if_n.ctrl_writeReg1    = if_b.ctrl_writeReg1;
    assign if_n.data_writeReg1    = if_b.data_writeReg1;
    assign if_n.ctrl_busySet      = if_b.ctrl_busySet;
    assign if_n.ctrl_busyReg      = if_b.ctrl_busyReg;
    assign if_n.ctrl_readRegA     = if_b.ctrl_readRegA;
    assign if_n.ctrl_readRegB     = if_b.ctrl_readRegB;

    // Architectural model: register contents and pending flags.
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        int  w0, w1, br;
        bit  e0, e1, bs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e0 = if_b.ctrl_writeEnable;  w0 = int'(if_b.ctrl_writeReg);
        e1 = if_b.ctrl_writeEnable1; w1 = int'(if_b.ctrl_writeReg1);
        bs = if_b.ctrl_busySet;      br = int'(if_b.ctrl_busyReg);
        if (e1 && w1 != 0 && !(e0 && w0 == w1)) m_mem[w1] = if_b.data_writeReg1;
        if (e0 && w0 != 0) m_mem[w0] = if_b.data_writeReg;
        if (e1 && w1 != 0 && !(bs && br == w1)) m_busy[w1] = 1'b0;
        if (bs && br != 0) m_busy[br] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] exp_data(int a, bit byp);
        if (a == 0 || !rst_n) return '0;
        if (byp && if_b.ctrl_writeEnable && int'(if_b.ctrl_writeReg) == a) return if_b.data_writeReg;
        if (byp && if_b.ctrl_writeEnable1 && int'(if_b.ctrl_writeReg1) == a) return if_b.data_writeReg1;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        if (a == 0 || !rst_n) return 1'b0;
        if (byp && if_b.ctrl_writeEnable1 && int'(if_b.ctrl_writeReg1) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        if_b.ctrl_writeEnable  = 1'b0; if_b.ctrl_writeReg  = '0; if_b.data_writeReg  = '0;
        if_b.ctrl_writeEnable1 = 1'b0; if_b.ctrl_writeReg1 = '0; if_b.data_writeReg1 = '0;
        if_b.ctrl_busySet      = 1'b0; if_b.ctrl_busyReg   = '0;
        if_b.ctrl_readRegA     = '0;   if_b.ctrl_readRegB  = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        if_b.ctrl_readRegA = 5; if_b.ctrl_readRegB = 6;
        if_b.ctrl_writeEnable = 1'b1; if_b.ctrl_writeReg = 5; if_b.data_writeReg = 32'hDEADBEEF;
        #1;
        tests++; if (if_b.data_readRegA !== 32'h0) begin fails++; $display("FAIL rst_hold_byp_data: got %h expected 0", if_b.data_readRegA); end
        tests++; if (if_n.data_readRegA !== 32'h0) begin fails++; $display("FAIL rst_hold_nobyp_data: got %h expected 0", if_n.data_readRegA); end
        tests++; if (if_b.stall !== 1'b0) begin fails++; $display("FAIL rst_hold_stall: got %b expected 0", if_b.stall); end
        @(negedge clock);
        rst_n = 1'b1;
        idle();
        if_b.ctrl_writeEnable = 1'b1; if_b.ctrl_writeReg = 5; if_b.data_writeReg = 32'hDEADBEEF;
        if_b.ctrl_busySet = 1'b1; if_b.ctrl_busyReg = 6;
        tick();
        idle();
        if_b.ctrl_readRegA = 5; if_b.ctrl_readRegB = 6;
        #1;
        tests++; if (if_n.data_readRegA !== 32'hDEADBEEF) begin fails++; $display("FAIL rst_pre_data: got %h expected deadbeef", if_n.data_readRegA); end
        tests++; if (if_b.busy_readRegB !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %b expected 1", if_b.busy_readRegB); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (if_b.data_readRegA !== 32'h0) begin fails++; $display("FAIL rst_async_byp_data: got %h expected 0", if_b.data_readRegA); end
        tests++; if (if_n.data_readRegA !== 32'h0) begin fails++; $display("FAIL rst_async_nobyp_data: got %h expected 0", if_n.data_readRegA); end
        tests++; if (if_b.busy_readRegB !== 1'b0) begin fails++; $display("FAIL rst_async_busy: got %b expected 0", if_b.busy_readRegB); end
        tests++; if (if_n.stall !== 1'b0) begin fails++; $display("FAIL rst_async_stall: got %b expected 0", if_n.stall); end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_r0();
        idle();
        if_b.ctrl_writeEnable  = 1'b1; if_b.data_writeReg  = 32'hFFFFFFFF;
        if_b.ctrl_writeEnable1 = 1'b1; if_b.data_writeReg1 = 32'hFFFFFFFF;
        if_b.ctrl_busySet = 1'b1;
        #1;
        tests++; if (if_b.data_readRegA !== 32'h0) begin fails++; $display("FAIL r0_same_data: got %h expected 0", if_b.data_readRegA); end
        tests++; if (if_b.busy_readRegA !== 1'b0) begin fails++; $display("FAIL r0_same_busy: got %b expected 0", if_b.busy_readRegA); end
        tick();
        idle();
        #1;
        tests++; if (if_n.data_readRegA !== 32'h0) begin fails++; $display("FAIL r0_next_data: got %h expected 0", if_n.data_readRegA); end
        tests++; if (if_b.busy_readRegA !== 1'b0) begin fails++; $display("FAIL r0_next_busy: got %b expected 0", if_b.busy_readRegA); end
        tests++; if (if_b.stall !== 1'b0) begin fails++; $display("FAIL r0_next_stall: got %b expected 0", if_b.stall); end
    endtask

    task automatic test_dual_write();
        idle();
        if_b.ctrl_busySet = 1'b1; if_b.ctrl_busyReg = 7;
        tick();
        idle();
        if_b.ctrl_readRegA = 7;
        #1;
        tests++; if (if_b.stall !== 1'b1) begin fails++; $display("FAIL dual_pre_stall: got %b expected 1", if_b.stall); end
        if_b.ctrl_writeEnable  = 1'b1; if_b.ctrl_writeReg  = 7; if_b.data_writeReg  = 32'h11;
        if_b.ctrl_writeEnable1 = 1'b1; if_b.ctrl_writeReg1 = 7; if_b.data_writeReg1 = 32'h22;
        #1;
        tests++; if (if_b.data_readRegA !== 32'h11) begin fails++; $display("FAIL dual_byp_data: got %h expected 11", if_b.data_readRegA); end
        tests++; if (if_b.busy_readRegA !== 1'b0) begin fails++; $display("FAIL dual_byp_busy: got %b expected 0", if_b.busy_readRegA); end
        tests++; if (if_n.busy_readRegA !== 1'b1) begin fails++; $display("FAIL dual_nobyp_busy: got %b expected 1", if_n.busy_readRegA); end
        tick();
        idle();
        if_b.ctrl_readRegA = 7;
        #1;
        tests++; if (if_n.data_readRegA !== 32'h11) begin fails++; $display("FAIL dual_next_data: got %h expected 11", if_n.data_readRegA); end
        tests++; if (if_n.busy_readRegA !== 1'b0) begin fails++; $display("FAIL dual_next_busy: got %b expected 0", if_n.busy_readRegA); end
    endtask

    task automatic test_bypass();
        idle();
        if_b.ctrl_writeEnable = 1'b1; if_b.ctrl_writeReg = 3; if_b.data_writeReg = 32'h1111;
        tick();
        if_b.data_writeReg = 32'hCAFE;
        if_b.ctrl_readRegA = 3;
        #1;
        tests++; if (if_b.data_readRegA !== 32'hCAFE) begin fails++; $display("FAIL byp_p0_same: got %h expected cafe", if_b.data_readRegA); end
        tests++; if (if_n.data_readRegA !== 32'h1111) begin fails++; $display("FAIL nobyp_p0_same: got %h expected 1111", if_n.data_readRegA); end
        tick();
        idle();
        if_b.ctrl_readRegA = 3;
        if_b.ctrl_writeEnable1 = 1'b1; if_b.ctrl_writeReg1 = 3; if_b.data_writeReg1 = 32'hBEEF;
        #1;
        tests++; if (if_n.data_readRegA !== 32'hCAFE) begin fails++; $display("FAIL nobyp_p0_next: got %h expected cafe", if_n.data_readRegA); end
        tests++; if (if_b.data_readRegA !== 32'hBEEF) begin fails++; $display("FAIL byp_p1_same: got %h expected beef", if_b.data_readRegA); end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        if_b.ctrl_busySet = 1'b1; if_b.ctrl_busyReg = 9; if_b.ctrl_readRegB = 9;
        #1;
        tests++; if (if_b.busy_readRegB !== 1'b0) begin fails++; $display("FAIL sb_set_same: got %b expected 0", if_b.busy_readRegB); end
        tick();
        idle();
        if_b.ctrl_readRegB = 9;
        #1;
        tests++; if (if_b.busy_readRegB !== 1'b1) begin fails++; $display("FAIL sb_set_next_busy: got %b expected 1", if_b.busy_readRegB); end
        tests++; if (if_n.stall !== 1'b1) begin fails++; $display("FAIL sb_set_next_stall: got %b expected 1", if_n.stall); end
        if_b.ctrl_writeEnable1 = 1'b1; if_b.ctrl_writeReg1 = 9; if_b.data_writeReg1 = 32'h1234;
        #1;
        tests++; if (if_b.busy_readRegB !== 1'b0) begin fails++; $display("FAIL sb_clr_byp_busy: got %b expected 0", if_b.busy_readRegB); end
        tests++; if (if_b.data_readRegB !== 32'h1234) begin fails++; $display("FAIL sb_clr_byp_data: got %h expected 1234", if_b.data_readRegB); end
        tests++; if (if_b.stall !== 1'b0) begin fails++; $display("FAIL sb_clr_byp_stall: got %b expected 0", if_b.stall); end
        tests++; if (if_n.stall !== 1'b1) begin fails++; $display("FAIL sb_clr_nobyp_stall: got %b expected 1", if_n.stall); end
        tick();
        idle();
        if_b.ctrl_readRegB = 9;
        #1;
        tests++; if (if_n.busy_readRegB !== 1'b0) begin fails++; $display("FAIL sb_clr_next_busy: got %b expected 0", if_n.busy_readRegB); end
        tests++; if (if_n.data_readRegB !== 32'h1234) begin fails++; $display("FAIL sb_clr_next_data: got %h expected 1234", if_n.data_readRegB); end
    endtask

    task automatic test_set_clear_race();
        idle();
        if_b.ctrl_busySet = 1'b1; if_b.ctrl_busyReg = 4;
        if_b.ctrl_writeEnable1 = 1'b1; if_b.ctrl_writeReg1 = 4; if_b.data_writeReg1 = 32'h5555;
        tick();
        idle();
        if_b.ctrl_readRegA = 4;
        #1;
        tests++; if (if_b.busy_readRegA !== 1'b1) begin fails++; $display("FAIL race_byp_busy: got %b expected 1", if_b.busy_readRegA); end
        tests++; if (if_n.busy_readRegA !== 1'b1) begin fails++; $display("FAIL race_nobyp_busy: got %b expected 1", if_n.busy_readRegA); end
        tests++; if (if_n.data_readRegA !== 32'h5555) begin fails++; $display("FAIL race_data: got %h expected 5555", if_n.data_readRegA); end
        tests++; if (if_b.stall !== 1'b1) begin fails++; $display("FAIL race_stall: got %b expected 1", if_b.stall); end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [DW-1:0] oda [2];
            logic [DW-1:0] odb [2];
            logic          oba [2];
            logic          obb [2];
            logic          ost [2];
            int            ra, rb;
            bit            byp, eba, ebb;
            bit            do_rst;
            if_b.ctrl_writeEnable  = 1'($urandom_range(0, 1));
            if_b.ctrl_writeReg     = pick_addr();
            if_b.data_writeReg     = $urandom;
            if_b.ctrl_writeEnable1 = 1'($urandom_range(0, 1));
            if_b.ctrl_writeReg1    = pick_addr();
            if_b.data_writeReg1    = $urandom;
            if_b.ctrl_busySet      = 1'($urandom_range(0, 1));
            if_b.ctrl_busyReg      = pick_addr();
            if_b.ctrl_readRegA     = pick_addr();
            if_b.ctrl_readRegB     = pick_addr();
            do_rst = ($urandom_range(0, 59) == 0);
            if (do_rst) begin
                rst_n = 1'b0;
                model_reset();
            end
            #1;
            ra = int'(if_b.ctrl_readRegA);
            rb = int'(if_b.ctrl_readRegB);
            oda[0] = if_b.data_readRegA; oda[1] = if_n.data_readRegA;
            odb[0] = if_b.data_readRegB; odb[1] = if_n.data_readRegB;
            oba[0] = if_b.busy_readRegA; oba[1] = if_n.busy_readRegA;
            obb[0] = if_b.busy_readRegB; obb[1] = if_n.busy_readRegB;
            ost[0] = if_b.stall;         ost[1] = if_n.stall;
            for (int d = 0; d < 2; d++) begin
                byp = (d == 0);
                eba = exp_busy(ra, byp);
                ebb = exp_busy(rb, byp);
                tests++; if (oda[d] !== exp_data(ra, byp)) begin fails++; $display("FAIL rand_dataA byp=%0d cyc=%0d r%0d: got %h expected %h", byp, n, ra, oda[d], exp_data(ra, byp)); end
                tests++; if (odb[d] !== exp_data(rb, byp)) begin fails++; $display("FAIL rand_dataB byp=%0d cyc=%0d r%0d: got %h expected %h", byp, n, rb, odb[d], exp_data(rb, byp)); end
                tests++; if (oba[d] !== eba) begin fails++; $display("FAIL rand_busyA byp=%0d cyc=%0d r%0d: got %b expected %b", byp, n, ra, oba[d], eba); end
                tests++; if (obb[d] !== ebb) begin fails++; $display("FAIL rand_busyB byp=%0d cyc=%0d r%0d: got %b expected %b", byp, n, rb, obb[d], ebb); end
                tests++; if (ost[d] !== (eba | ebb)) begin fails++; $display("FAIL rand_stall byp=%0d cyc=%0d: got %b expected %b", byp, n, ost[d], eba | ebb); end
            end
            tick();
            if (do_rst) rst_n = 1'b1;
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        model_reset();
        #1;
        rst_n = 1'b0;
        test_reset();
        test_r0();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_set_clear_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
